// File: rtl/pwm_duty_meter.sv
// PWM receive meter: reports high time and period of pwm_in in clk cycles, flags a stuck input.
// Optional glitch filter enabled by defining PWM_METER_GLITCH_FILTER_EN.
//
//   state | meaning
//   IDLE  | counters cleared, waiting for the rise that arms a measurement
//   MEAS  | counting the current period; each rise reports and restarts
module pwm_duty_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck,
   output logic             stuck_lvl
);

   localparam logic IDLE = 1'b0;
   localparam logic MEAS = 1'b1;

   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync1, sync2;
   logic             cur, prev, rise;
   logic             state;
   logic [CNT_W-1:0] pcnt, hcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
      end
   end

`ifdef PWM_METER_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic       filt_q;

   // level only follows the synced input once three consecutive samples agree
   assign cur = (sync2 == hist[0] && sync2 == hist[1]) ? sync2 : filt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist   <= 2'b00;
         filt_q <= 1'b0;
      end else begin
         hist   <= {hist[0], sync2};
         filt_q <= cur;
      end
   end
`else
   assign cur = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= cur;
   end

   assign rise = cur & ~prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pcnt       <= '0;
         hcnt       <= '0;
         high_cnt   <= '0;
         period_cnt <= '0;
         meas_valid <= 1'b0;
         stuck      <= 1'b0;
         stuck_lvl  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= MEAS;
                  pcnt  <= CNT_ONE;
                  hcnt  <= CNT_ONE;
               end else begin
                  pcnt <= '0;
                  hcnt <= '0;
               end
            end
            default: begin
               // a rise on the timeout cycle still completes a valid period
               if (rise) begin
                  high_cnt   <= hcnt;
                  period_cnt <= pcnt;
                  meas_valid <= 1'b1;
                  stuck      <= 1'b0;
                  pcnt       <= CNT_ONE;
                  hcnt       <= CNT_ONE;
               end else if (pcnt == TO_VAL) begin
                  stuck     <= 1'b1;
                  stuck_lvl <= cur;
                  state     <= IDLE;
                  pcnt      <= '0;
                  hcnt      <= '0;
               end else begin
                  pcnt <= pcnt + CNT_ONE;
                  hcnt <= hcnt + CNT_W'(cur);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter (filter disabled, TIMEOUT = 20): per-cycle comparison against
// a model built from rise positions and high-sample sums over the recorded input stream.
module tb_pwm_duty_meter;

   localparam int CNT_W = 16;
   localparam int TO    = 20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] high_cnt, period_cnt;
   logic             meas_valid, stuck, stuck_lvl;

   int errors = 0;
   int checks = 0;

   bit               hist[$];
   int               last_rise;
   bit               armed;
   logic             exp_valid, exp_stuck, exp_lvl;
   logic [CNT_W-1:0] exp_high, exp_period;

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .meas_valid (meas_valid),
      .stuck      (stuck),
      .stuck_lvl  (stuck_lvl)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      hist.delete();
      armed      = 1'b0;
      last_rise  = 0;
      exp_valid  = 1'b0;
      exp_stuck  = 1'b0;
      exp_lvl    = 1'b0;
      exp_high   = '0;
      exp_period = '0;
   endtask

   // Drive one input sample, advance one clock, update the model, compare all outputs.
   // A rise in the sample taken at edge m is reported at edge m+2.
   task automatic step(input bit v);
      int k, m, s;
      bit prevb;
      pwm_in = v;
      @(posedge clk);
      hist.push_back(v);
      k = hist.size() - 1;
      m = k - 2;
      exp_valid = 1'b0;
      if (m >= 0) begin
         prevb = (m == 0) ? 1'b0 : hist[m-1];
         if (hist[m] && !prevb) begin
            if (armed) begin
               s = 0;
               for (int i = last_rise; i < m; i++) s += int'(hist[i]);
               exp_valid  = 1'b1;
               exp_high   = CNT_W'(s);
               exp_period = CNT_W'(m - last_rise);
               exp_stuck  = 1'b0;
            end
            armed     = 1'b1;
            last_rise = m;
         end else if (armed && (m - last_rise) == TO) begin
            exp_stuck = 1'b1;
            exp_lvl   = hist[m];
            armed     = 1'b0;
         end
      end
      #1;
      checks++;
      if ({meas_valid, stuck, stuck_lvl, high_cnt, period_cnt} !==
          {exp_valid, exp_stuck, exp_lvl, exp_high, exp_period}) begin
         errors++;
         $display("FAIL outputs cycle %0d: got valid=%0b stuck=%0b lvl=%0b high=%0d period=%0d, want valid=%0b stuck=%0b lvl=%0b high=%0d period=%0d",
                  k, meas_valid, stuck, stuck_lvl, high_cnt, period_cnt,
                  exp_valid, exp_stuck, exp_lvl, exp_high, exp_period);
      end
      @(negedge clk);
   endtask

   task automatic pwm(input int p, input int h, input int n);
      for (int j = 0; j < n; j++)
         for (int i = 0; i < p; i++) step(i < h);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({meas_valid, stuck, stuck_lvl, high_cnt, period_cnt} !== '0) begin
         errors++;
         $display("FAIL %s: got valid=%0b stuck=%0b lvl=%0b high=%0d period=%0d, want all 0",
                  name, meas_valid, stuck, stuck_lvl, high_cnt, period_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic();
      pwm(10, 3, 6);
   endtask

   task automatic test_duty_sweep();
      for (int h = 1; h <= 9; h++) pwm(10, h, 3);
      pwm(2, 1, 6);
   endtask

   task automatic test_stuck_high();
      pwm(10, 4, 3);
      repeat (30) step(1'b1);
      pwm(10, 4, 3);
   endtask

   task automatic test_stuck_low();
      pwm(8, 2, 3);
      repeat (30) step(1'b0);
      pwm(8, 2, 3);
   endtask

   task automatic test_timeout_boundary();
      pwm(20, 5, 3);
      pwm(21, 5, 3);
      pwm(20, 1, 3);
   endtask

   task automatic test_mid_reset();
      pwm(10, 3, 3);
      for (int i = 0; i < 4; i++) step(i < 3);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset_immediate");
      model_reset();
      pwm_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      pwm(10, 3, 4);
   endtask

   task automatic test_glitch();
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 20; i++) step(i < 10 && i != 4 && i != 5);
   endtask

   task automatic test_random();
      int p, h;
      for (int j = 0; j < 40; j++) begin
         p = $urandom_range(2, 24);
         h = $urandom_range(1, p - 1);
         pwm(p, h, 1);
      end
      for (int i = 0; i < 400; i++) step(($urandom_range(0, 3) == 0) ? ~pwm_in : pwm_in);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_sweep();
      test_stuck_high();
      test_stuck_low();
      test_timeout_boundary();
      test_mid_reset();
      test_glitch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
